wave_profile_gen: RTL
=====================

// Module: wave_profile_gen
// PURPOSE
//   Upstream feeder for the display stage. Once per frame, on vsync assertion, it
//   computes the sine-wave surface profile: one vertical pixel row per screen column.
//   It streams N_SAMPLES values over wave_prof, one per wave_clk strobe, starting at
//   column 0. The display stage clocks these into its column buffer.
// PARAMETERS
//   N_SAMPLES  1024  samples (columns) streamed per frame
//   PHASE_W    16    phase accumulator width; one full sine period = 2^PHASE_W
//   LUT_AW     6     quarter-wave LUT address width (2^LUT_AW entries)
//   CENTER     382   vertical row of the zero-amplitude profile
//   MAX_Y      767   largest legal output row; results are clamped to [0,MAX_Y]
// PORTS
//   vclock     in   1        65 MHz pixel clock; the only clock
//   reset      in   1        synchronous, active-high
//   vsync      in   1        active low; its falling edge triggers a frame
//   enable     in   1        frame trigger is accepted only while high
//   freq_step  in   PHASE_W  phase increment per column
//   amplitude  in   8        unsigned peak deflection, in pixels
//   offset     in   11       horizontal scroll, in columns
//   wave_prof  out  10       profile row for the current sample
//   wave_clk   out  1        one-cycle strobe; wave_prof is valid while it is high
//   busy       out  1        high while a frame is being generated
//   frame_done out  1        one-cycle pulse coincident with the last strobe
//   overrun    out  1        sticky; set when a trigger arrives while busy
// BEHAVIOUR
//   Reset: all outputs 0; FSM in IDLE; pipeline valid bits cleared. Reset wins over
//   every other event. A reset mid-stream aborts the frame with no further strobes.
//   Trigger: vsync_q is the registered copy of vsync. A trigger is
//   (vsync_q==1 && vsync==0 && enable) in cycle E.
//   FSM states and transitions:
//     IDLE   -> LOAD on a trigger.
//     LOAD   -> STREAM after one cycle. LOAD latches freq_step, amplitude and offset,
//               sets phase = (offset*freq_step) mod 2^PHASE_W, and clears idx.
//     STREAM -> FLUSH after idx==N_SAMPLES-1 is issued. STREAM issues one index per
//               cycle, then does phase += freq_step (wraps mod 2^PHASE_W) and idx++.
//     FLUSH  -> IDLE once the pipeline is empty.
//   Pipeline (3 stages):
//     S1: LUT read. q = phase[PHASE_W-1 -: 2], a = next LUT_AW bits.
//         mag = q[0] ? lut[~a] : lut[a]; sign = q[1].
//     S2: prod = signed(amplitude) * (sign ? -mag : mag), 16-bit signed.
//     S3: y = CENTER - (prod >>> 7), clamped to [0,MAX_Y]. Register it to wave_prof
//         and pulse wave_clk.
//   Timing:
//     busy is high in E+1 .. E+N_SAMPLES+3.
//     wave_clk is high in exactly E+4 .. E+N_SAMPLES+3, contiguous, N_SAMPLES strobes.
//     frame_done is high only in E+N_SAMPLES+3.
//   Boundary rules:
//     - A trigger while busy is ignored and sets overrun; the current frame completes.
//     - enable falling mid-frame does not stop the frame.
//     - Input changes mid-frame have no effect; values are latched in LOAD.
//     - wave_prof holds its last value while wave_clk is low.
//     - amplitude 0 gives CENTER for every sample. Phase wrap is seamless.
//   LUT contents: lut[i] = round(127*sin(pi/2*(i+0.5)/2^LUT_AW)), unsigned 7-bit;
//   lut[0]=2, lut[63]=127.
// STRUCTURE
//   Shared package wave_pkg holds: PHASE_W, LUT_AW, CENTER, MAX_Y, N_SAMPLES, and the
//   FSM state typedef {IDLE, LOAD, STREAM, FLUSH}.
//   One sub-module, sine_quarter_lut: a registered ROM with 1-cycle latency, mapped to
//   BRAM or LUTs. The FSM, accumulator, multiply and clamp stay in this module.
// TESTING
//   1. amplitude=0, enable=1, vsync 1->0 -> 1024 strobes, every wave_prof=382;
//      frame_done once, in the same cycle as strobe 1024.
//   2. freq_step=16384, amplitude=128, offset=0 -> wave_prof repeats 380,255,384,509
//      for all 1024 samples.
//   3. As test 2 but offset=1 -> sequence starts 255,384,509,380.
//   4. Second vsync falling edge at strobe 500 -> overrun=1; strobe count stays 1024;
//      sequence is unchanged.
//   5. reset pulsed at strobe 300 -> next cycle wave_clk=0, busy=0, wave_prof=0,
//      overrun=0; the next trigger gives a full clean frame.
//   6. enable=0 on the vsync edge -> no strobes, busy stays 0. Timing check: first
//      strobe exactly 4 cycles after the edge-detect cycle E.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared constants and types for the wave profile generator.
//   PHASE_W    phase accumulator width (one sine period = 2^PHASE_W)
//   LUT_AW     quarter-wave LUT address width
//   MAG_W      quarter-wave LUT data width (unsigned magnitude)
//   CENTER     output row of the zero-amplitude profile
//   MAX_Y      largest legal output row
//   N_SAMPLES  samples (columns) streamed per frame
//   wave_state_t  frame sequencer states
package wave_pkg;

  localparam int PHASE_W   = 16;
  localparam int LUT_AW    = 6;
  localparam int MAG_W     = 7;
  localparam int CENTER    = 382;
  localparam int MAX_Y     = 767;
  localparam int N_SAMPLES = 1024;
  localparam int IDX_W     = $clog2(N_SAMPLES);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    FLUSH
  } wave_state_t;

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine ROM with one cycle of read latency.
//   lut[i] = round(127 * sin(pi/2 * (i + 0.5) / 64)), unsigned 7-bit.
// Ports:
//   vclock  in   pixel clock
//   i_addr  in   LUT_AW-bit quarter-wave address
//   o_mag   out  MAG_W-bit magnitude, registered
module sine_quarter_lut
  import wave_pkg::*;
(
  input  logic              vclock,
  input  logic [LUT_AW-1:0] i_addr,
  output logic [MAG_W-1:0]  o_mag
);

  function automatic logic [MAG_W-1:0] quarter_sine(input logic [LUT_AW-1:0] a);
    logic [MAG_W-1:0] v;
    v = '0;
    case (a)
      6'd0:  v = 7'd2;    6'd1:  v = 7'd5;    6'd2:  v = 7'd8;    6'd3:  v = 7'd11;
      6'd4:  v = 7'd14;   6'd5:  v = 7'd17;   6'd6:  v = 7'd20;   6'd7:  v = 7'd23;
      6'd8:  v = 7'd26;   6'd9:  v = 7'd29;   6'd10: v = 7'd32;   6'd11: v = 7'd35;
      6'd12: v = 7'd38;   6'd13: v = 7'd41;   6'd14: v = 7'd44;   6'd15: v = 7'd47;
      6'd16: v = 7'd50;   6'd17: v = 7'd53;   6'd18: v = 7'd56;   6'd19: v = 7'd58;
      6'd20: v = 7'd61;   6'd21: v = 7'd64;   6'd22: v = 7'd67;   6'd23: v = 7'd69;
      6'd24: v = 7'd72;   6'd25: v = 7'd74;   6'd26: v = 7'd77;   6'd27: v = 7'd79;
      6'd28: v = 7'd82;   6'd29: v = 7'd84;   6'd30: v = 7'd86;   6'd31: v = 7'd89;
      6'd32: v = 7'd91;   6'd33: v = 7'd93;   6'd34: v = 7'd95;   6'd35: v = 7'd97;
      6'd36: v = 7'd99;   6'd37: v = 7'd101;  6'd38: v = 7'd103;  6'd39: v = 7'd105;
      6'd40: v = 7'd106;  6'd41: v = 7'd108;  6'd42: v = 7'd110;  6'd43: v = 7'd111;
      6'd44: v = 7'd113;  6'd45: v = 7'd114;  6'd46: v = 7'd115;  6'd47: v = 7'd117;
      6'd48: v = 7'd118;  6'd49: v = 7'd119;  6'd50: v = 7'd120;  6'd51: v = 7'd121;
      6'd52: v = 7'd122;  6'd53: v = 7'd123;  6'd54: v = 7'd124;  6'd55: v = 7'd124;
      6'd56: v = 7'd125;  6'd57: v = 7'd125;  6'd58: v = 7'd126;  6'd59: v = 7'd126;
      6'd60: v = 7'd127;  6'd61: v = 7'd127;  6'd62: v = 7'd127;  6'd63: v = 7'd127;
      default: v = '0;
    endcase
    return v;
  endfunction

  always_ff @(posedge vclock) begin
    o_mag <= quarter_sine(i_addr);
  end

endmodule

// File: rtl/wave_profile_gen.sv
// Per-frame sine surface profile generator for the display stage.
// On an enabled vsync falling edge it latches the wave settings and streams
// N_SAMPLES profile rows, one per wave_clk strobe, starting at column 0.
// Ports:
//   vclock      in   pixel clock, the only clock
//   reset       in   synchronous, active-high
//   vsync       in   active low; falling edge triggers a frame
//   enable      in   frame trigger accepted only while high
//   freq_step   in   phase increment per column
//   amplitude   in   unsigned peak deflection in pixels
//   offset      in   horizontal scroll in columns
//   wave_prof   out  profile row, valid while wave_clk is high, held otherwise
//   wave_clk    out  one-cycle strobe per sample
//   busy        out  high while a frame is being generated
//   frame_done  out  pulse coincident with the last strobe
//   overrun     out  sticky; trigger seen while busy
module wave_profile_gen
  import wave_pkg::*;
(
  input  logic               vclock,
  input  logic               reset,
  input  logic               vsync,
  input  logic               enable,
  input  logic [PHASE_W-1:0] freq_step,
  input  logic [7:0]         amplitude,
  input  logic [10:0]        offset,
  output logic [9:0]         wave_prof,
  output logic               wave_clk,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun
);

  localparam logic signed [15:0] C_CENTER = 16'(CENTER);
  localparam logic signed [15:0] C_MAX_Y  = 16'(MAX_Y);

  wave_state_t        r_state;
  logic               r_vsync_q;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_step;
  logic [7:0]         r_amp;
  logic [IDX_W-1:0]   r_idx;
  logic               r_s1_valid;
  logic               r_s1_sign;
  logic               r_s1_last;

  logic               w_trig;
  logic               w_issue;
  logic               w_last_idx;
  logic [1:0]         w_q;
  logic [LUT_AW-1:0]  w_a;
  logic [LUT_AW-1:0]  w_lut_addr;
  logic [MAG_W-1:0]   w_mag;
  logic [PHASE_W-1:0] w_load_phase;
  logic signed [15:0] w_amp_s;
  logic signed [15:0] w_mag_s;
  logic signed [15:0] w_prod;
  logic signed [15:0] w_defl;
  logic signed [15:0] w_y;
  logic [9:0]         w_row;

  assign w_trig       = r_vsync_q & ~vsync & enable;
  assign w_issue      = (r_state == STREAM);
  assign w_last_idx   = (r_idx == IDX_W'(N_SAMPLES - 1));
  assign w_q          = r_phase[PHASE_W-1 -: 2];
  assign w_a          = r_phase[PHASE_W-3 -: LUT_AW];
  // Odd quadrants walk the quarter wave backwards.
  assign w_lut_addr   = w_q[0] ? ~w_a : w_a;
  // Truncation to PHASE_W bits is the mod 2^PHASE_W wrap.
  assign w_load_phase = PHASE_W'(offset) * freq_step;

  sine_quarter_lut u_lut (
    .vclock (vclock),
    .i_addr (w_lut_addr),
    .o_mag  (w_mag)
  );

  // Frame sequencer: IDLE -> LOAD -> STREAM (N_SAMPLES issues) -> FLUSH -> IDLE.
  always_ff @(posedge vclock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_vsync_q <= 1'b0;
      r_phase   <= '0;
      r_step    <= '0;
      r_amp     <= '0;
      r_idx     <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
      if (w_trig && (r_state != IDLE)) begin
        overrun <= 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (w_trig) begin
            r_state <= LOAD;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          r_step  <= freq_step;
          r_amp   <= amplitude;
          r_phase <= w_load_phase;
          r_idx   <= '0;
          r_state <= STREAM;
        end
        STREAM: begin
          r_phase <= r_phase + r_step;
          r_idx   <= r_idx + 1'b1;
          if (w_last_idx) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (!r_s1_valid) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // S2: signed deflection. The multiply and the S3 clamp share one cycle so
  // that the ROM register plus the output register give the two-cycle
  // issue-to-strobe latency (first strobe four cycles after the trigger).
  assign w_amp_s = $signed({8'd0, r_amp});
  assign w_mag_s = r_s1_sign ? -$signed({9'd0, w_mag}) : $signed({9'd0, w_mag});
  assign w_prod  = w_amp_s * w_mag_s;
  assign w_defl  = w_prod >>> 7;
  assign w_y     = C_CENTER - w_defl;

  // S3: clamp to [0, MAX_Y].
  always_comb begin
    w_row = '0;
    if (w_y < 0) begin
      w_row = '0;
    end else if (w_y > C_MAX_Y) begin
      w_row = 10'(MAX_Y);
    end else begin
      w_row = w_y[9:0];
    end
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_last  <= 1'b0;
      wave_prof  <= '0;
      wave_clk   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      r_s1_valid <= w_issue;
      r_s1_sign  <= w_q[1];
      r_s1_last  <= w_issue & w_last_idx;
      wave_clk   <= r_s1_valid;
      frame_done <= r_s1_valid & r_s1_last;
      if (r_s1_valid) begin
        wave_prof <= w_row;
      end
    end
  end

endmodule
